// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the PPU hazard controller: forwarding-select encodings and the
// destination-tracking slot carried through EX/MEM/WB.
package ppu_hazard_pkg;

   // Slot rd field is wide enough for any supported REG_AW; narrower addresses are zero-extended.
   localparam int SLOT_RD_W = 8;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   typedef struct packed {
      logic                 v;
      logic [SLOT_RD_W-1:0] rd;
      logic                 rf_en;
      logic                 load;
   } hazard_slot_t;

   localparam hazard_slot_t BUBBLE_SLOT = '{v: 1'b0, rd: {SLOT_RD_W{1'b0}}, rf_en: 1'b0, load: 1'b0};

   function automatic logic slot_writes(input hazard_slot_t s);
      return s.v & s.rf_en & (s.rd != {SLOT_RD_W{1'b0}});
   endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: youngest writing slot with a matching rd wins;
// a load that cannot forward yet raises load_match instead.
module fwd_select
   import ppu_hazard_pkg::*;
#(
   parameter int LOAD_LAT = 1
)(
   input  logic [SLOT_RD_W-1:0] src,
   input  logic                 used,
   input  hazard_slot_t         ex_slot,
   input  hazard_slot_t         mem_slot,
   input  hazard_slot_t         wb_slot,
   output logic [1:0]           sel,
   output logic                 load_match
);

   logic unused_wb_load;
   assign unused_wb_load = &{1'b0, wb_slot.load};

   // Priority match EX > MEM > WB; loads still in flight select the regfile and flag a stall.
   always_comb begin
      sel        = FWD_RF;
      load_match = 1'b0;
      if (used && (src != {SLOT_RD_W{1'b0}})) begin
         if (slot_writes(ex_slot) && (ex_slot.rd == src)) begin
            if (ex_slot.load) begin
               load_match = 1'b1;
            end else begin
               sel = FWD_EX;
            end
         end else if (slot_writes(mem_slot) && (mem_slot.rd == src)) begin
            if (mem_slot.load && (LOAD_LAT == 2)) begin
               load_match = 1'b1;
            end else begin
               sel = FWD_MEM;
            end
         end else if (slot_writes(wb_slot) && (wb_slot.rd == src)) begin
            sel = FWD_WB;
         end else begin
            sel = FWD_RF;
         end
      end else begin
         sel = FWD_RF;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage PPU pipeline: tracks EX/MEM/WB
// destinations, drives forwarding selects, stalls, flushes and freeze enables.
module pipeline_hazard_ctrl
   import ppu_hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      id_valid,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_rf_en,
   input  logic                      id_load,
   input  logic [NUM_SRC*REG_AW-1:0] id_src,
   input  logic [NUM_SRC-1:0]        id_src_used,
   input  logic                      ex_branch_taken,
   input  logic                      mem_busy,
   output logic [2*NUM_SRC-1:0]      fwd_sel,
   output logic                      npc_le,
   output logic                      pc_le,
   output logic                      if_id_le,
   output logic                      if_id_flush,
   output logic                      cu_s,
   output logic [CNT_W-1:0]          stall_cnt,
   output logic [CNT_W-1:0]          flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   hazard_slot_t ex_slot, mem_slot, wb_slot, id_slot;
   logic [2*NUM_SRC-1:0] op_sel;
   logic [NUM_SRC-1:0]   op_load_match;
   logic                 load_use;
   logic                 le;

   assign id_slot  = '{v: id_valid, rd: SLOT_RD_W'(id_rd), rf_en: id_rf_en, load: id_load};
   assign load_use = id_valid & (|op_load_match);

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_op
      logic [SLOT_RD_W-1:0] src_ext;
      assign src_ext = SLOT_RD_W'(id_src[k*REG_AW +: REG_AW]);
      fwd_select #(.LOAD_LAT(LOAD_LAT)) u_fwd (
         .src        (src_ext),
         .used       (id_src_used[k]),
         .ex_slot    (ex_slot),
         .mem_slot   (mem_slot),
         .wb_slot    (wb_slot),
         .sel        (op_sel[2*k +: 2]),
         .load_match (op_load_match[k])
      );
   end

   // Pipe control by priority: reset > mem_busy > taken branch > load-use > normal.
   always_comb begin
      le          = 1'b0;
      if_id_flush = 1'b0;
      cu_s        = 1'b0;
      fwd_sel     = op_sel;
      if (reset) begin
         cu_s    = 1'b1;
         fwd_sel = {(2*NUM_SRC){1'b0}};
      end else if (mem_busy) begin
         le = 1'b0;
      end else if (ex_branch_taken) begin
         le          = 1'b1;
         if_id_flush = 1'b1;
         cu_s        = 1'b1;
      end else if (load_use) begin
         cu_s = 1'b1;
      end else begin
         le = 1'b1;
      end
      npc_le   = le;
      pc_le    = le;
      if_id_le = le;
   end

   // Slot shift register and saturating performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_slot   <= BUBBLE_SLOT;
         mem_slot  <= BUBBLE_SLOT;
         wb_slot   <= BUBBLE_SLOT;
         stall_cnt <= {CNT_W{1'b0}};
         flush_cnt <= {CNT_W{1'b0}};
      end else if (mem_busy) begin
         ex_slot   <= ex_slot;
         mem_slot  <= mem_slot;
         wb_slot   <= wb_slot;
         stall_cnt <= stall_cnt;
         flush_cnt <= flush_cnt;
      end else begin
         mem_slot <= ex_slot;
         wb_slot  <= mem_slot;
         if (ex_branch_taken) begin
            ex_slot <= BUBBLE_SLOT;
            if (flush_cnt != CNT_MAX) begin
               flush_cnt <= flush_cnt + CNT_W'(1);
            end else begin
               flush_cnt <= flush_cnt;
            end
         end else if (load_use) begin
            ex_slot <= BUBBLE_SLOT;
            if (stall_cnt != CNT_MAX) begin
               stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
               stall_cnt <= stall_cnt;
            end
         end else begin
            ex_slot <= id_slot;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: instance a (LOAD_LAT=1, CNT_W=16) and instance b (LOAD_LAT=2, CNT_W=2).
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       a_valid, a_rf_en, a_load, a_br, a_busy;
   logic [4:0] a_rd;
   logic [9:0] a_src;
   logic [1:0] a_used;
   logic [3:0] a_fwd;
   logic       a_npc_le, a_pc_le, a_if_id_le, a_flush, a_cu_s;
   logic [15:0] a_stall_cnt, a_flush_cnt;

   logic       b_valid, b_rf_en, b_load, b_br, b_busy;
   logic [4:0] b_rd;
   logic [9:0] b_src;
   logic [1:0] b_used;
   logic [3:0] b_fwd;
   logic       b_npc_le, b_pc_le, b_if_id_le, b_flush, b_cu_s;
   logic [1:0] b_stall_cnt, b_flush_cnt;

   int errors = 0;
   int checks = 0;

   pipeline_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(16)) u_a (
      .clk(clk), .reset(reset), .id_valid(a_valid), .id_rd(a_rd), .id_rf_en(a_rf_en),
      .id_load(a_load), .id_src(a_src), .id_src_used(a_used), .ex_branch_taken(a_br),
      .mem_busy(a_busy), .fwd_sel(a_fwd), .npc_le(a_npc_le), .pc_le(a_pc_le),
      .if_id_le(a_if_id_le), .if_id_flush(a_flush), .cu_s(a_cu_s),
      .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
   );

   pipeline_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(2), .CNT_W(2)) u_b (
      .clk(clk), .reset(reset), .id_valid(b_valid), .id_rd(b_rd), .id_rf_en(b_rf_en),
      .id_load(b_load), .id_src(b_src), .id_src_used(b_used), .ex_branch_taken(b_br),
      .mem_busy(b_busy), .fwd_sel(b_fwd), .npc_le(b_npc_le), .pc_le(b_pc_le),
      .if_id_le(b_if_id_le), .if_id_flush(b_flush), .cu_s(b_cu_s),
      .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [4:0] rd, input logic rf, input logic ld,
                          input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
      a_valid = v; a_rd = rd; a_rf_en = rf; a_load = ld; a_src = {s1, s0}; a_used = used;
   endtask

   task automatic drive_b(input logic v, input logic [4:0] rd, input logic rf, input logic ld,
                          input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
      b_valid = v; b_rd = rd; b_rf_en = rf; b_load = ld; b_src = {s1, s0}; b_used = used;
   endtask

   // {npc_le, pc_le, if_id_le, if_id_flush, cu_s}
   function automatic logic [4:0] ctl_a();
      return {a_npc_le, a_pc_le, a_if_id_le, a_flush, a_cu_s};
   endfunction
   function automatic logic [4:0] ctl_b();
      return {b_npc_le, b_pc_le, b_if_id_le, b_flush, b_cu_s};
   endfunction

   initial begin
      reset = 1'b1;
      a_br = 1'b0; a_busy = 1'b0; b_br = 1'b0; b_busy = 1'b0;
      drive_a(1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 5'd3, 2'b11);
      drive_b(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      tick();
      tick();
      check("a_reset_ctl", ctl_a(), 5'b00001);
      check("a_reset_fwd", a_fwd, 4'b0000);
      check("a_reset_stall", a_stall_cnt, 16'd0);
      check("a_reset_flush", a_flush_cnt, 16'd0);
      reset = 1'b0;

      // add r3,r1,r2 then sub r4,r3,r5
      drive_a(1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11);
      #1 check("t1_add_ctl", ctl_a(), 5'b11100);
      check("t1_add_fwd", a_fwd, 4'b0000);
      tick();
      drive_a(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd5, 2'b11);
      #1 check("t1_sub_fwd", a_fwd, 4'b0001);
      check("t1_sub_ctl", ctl_a(), 5'b11100);
      tick();
      check("t1_stall_cnt", a_stall_cnt, 16'd0);

      // lw r8 then add r10,r8,r1
      drive_a(1'b1, 5'd8, 1'b1, 1'b1, 5'd9, 5'd0, 2'b01);
      tick();
      drive_a(1'b1, 5'd10, 1'b1, 1'b0, 5'd8, 5'd1, 2'b11);
      #1 check("t2_stall_ctl", ctl_a(), 5'b00001);
      tick();
      check("t2_stall_cnt1", a_stall_cnt, 16'd1);
      check("t2_fwd_mem", a_fwd, 4'b0010);
      check("t2_resume_ctl", ctl_a(), 5'b11100);
      tick();
      check("t2_stall_cnt_hold", a_stall_cnt, 16'd1);

      // load to r0, then read r0: no forward, no stall
      drive_a(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
      tick();
      drive_a(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 5'd0, 2'b11);
      #1 check("t3_r0_fwd", a_fwd, 4'b0000);
      check("t3_r0_ctl", ctl_a(), 5'b11100);
      tick();

      // r5 in EX and WB, r6 in MEM
      drive_a(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
      tick();
      drive_a(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
      tick();
      drive_a(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
      tick();
      drive_a(1'b1, 5'd7, 1'b0, 1'b0, 5'd5, 5'd6, 2'b11);
      #1 check("t4_ex_prio", a_fwd, 4'b1001);
      drive_a(1'b1, 5'd7, 1'b0, 1'b0, 5'd5, 5'd6, 2'b01);
      #1 check("t4_unused_op", a_fwd, 4'b0001);
      tick();

      // taken branch coinciding with load-use
      drive_a(1'b1, 5'd12, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
      tick();
      drive_a(1'b1, 5'd13, 1'b1, 1'b0, 5'd12, 5'd0, 2'b01);
      a_br = 1'b1;
      #1 check("t5_branch_ctl", ctl_a(), 5'b11111);
      tick();
      a_br = 1'b0;
      check("t5_flush_cnt", a_flush_cnt, 16'd1);
      check("t5_stall_unch", a_stall_cnt, 16'd1);

      // mem_busy held for 3 cycles
      a_busy = 1'b1;
      #1 check("t5_busy_ctl", ctl_a(), 5'b00000);
      check("t5_busy_fwd", a_fwd, 4'b0010);
      tick();
      tick();
      check("t5_busy_ctl2", ctl_a(), 5'b00000);
      tick();
      check("t5_busy_fwd_held", a_fwd, 4'b0010);
      check("t5_busy_stall", a_stall_cnt, 16'd1);
      check("t5_busy_flush", a_flush_cnt, 16'd1);
      a_busy = 1'b0;
      #1 check("t5_unbusy_ctl", ctl_a(), 5'b11100);
      tick();
      check("t5_final_stall", a_stall_cnt, 16'd1);

      // Instance b: LOAD_LAT=2, CNT_W=2
      drive_a(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive_b(1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
      tick();
      drive_b(1'b1, 5'd10, 1'b1, 1'b0, 5'd8, 5'd1, 2'b11);
      #1 check("b_stall1_ctl", ctl_b(), 5'b00001);
      tick();
      check("b_stall_cnt1", b_stall_cnt, 2'd1);
      check("b_stall2_ctl", ctl_b(), 5'b00001);
      check("b_stall2_fwd", b_fwd, 4'b0000);
      tick();
      check("b_stall_cnt2", b_stall_cnt, 2'd2);
      check("b_fwd_wb", b_fwd, 4'b0011);
      check("b_resume_ctl", ctl_b(), 5'b11100);
      tick();
      check("b_stall_cnt_hold", b_stall_cnt, 2'd2);

      // five flushes saturate a 2-bit counter
      drive_b(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      b_br = 1'b1;
      tick();
      tick();
      tick();
      check("b_flush_3", b_flush_cnt, 2'd3);
      tick();
      tick();
      check("b_flush_sat", b_flush_cnt, 2'd3);
      b_br = 1'b0;

      // reset during a LOAD_LAT=2 stall
      drive_b(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
      tick();
      drive_b(1'b1, 5'd11, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01);
      tick();
      check("b_stall_sat", b_stall_cnt, 2'd3);
      check("b_mid_stall_ctl", ctl_b(), 5'b00001);
      reset = 1'b1;
      #1 check("b_rst_ctl", ctl_b(), 5'b00001);
      check("b_rst_fwd", b_fwd, 4'b0000);
      tick();
      check("b_rst_stall", b_stall_cnt, 2'd0);
      check("b_rst_flush", b_flush_cnt, 2'd0);
      check("b_rst_ctl_held", ctl_b(), 5'b00001);
      reset = 1'b0;
      #1 check("b_post_rst_ctl", ctl_b(), 5'b11100);
      check("b_post_rst_fwd", b_fwd, 4'b0000);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard/forwarding controller for the 5-stage PPU pipeline (IF/ID/EX/MEM/WB).
- Owns its own EX/MEM/WB destination-tracking shift register, fed each cycle from the ID stage.
- Generates per-operand forwarding selects, load-use stalls (configurable load latency), branch flushes and external memory-busy freezes.
- Keeps saturating stall/flush performance counters.
- Sits between the control unit/ID mux and the EX operand muxes. Drives the nPC, PC and IF/ID load enables and the CU bubble select.

Parameters:
REG_AW, 5, register-address width; register 0 is hard-wired zero.
NUM_SRC, 2, number of source operands checked per ID instruction (1..3).
LOAD_LAT, 1, load data ready after MEM (1) or after WB entry (2).
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rd  in  REG_AW  ID destination register
id_rf_en  in  1  ID instruction writes the register file
id_load  in  1  ID instruction is a load
id_src  in  NUM_SRC*REG_AW  ID source registers; operand k is at [k*REG_AW +: REG_AW]
id_src_used  in  NUM_SRC  operand k is actually read
ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
mem_busy  in  1  data memory not ready; freeze the whole pipe
fwd_sel  out  2*NUM_SRC  per operand: 00 regfile, 01 EX, 10 MEM, 11 WB
npc_le  out  1  nPC load enable
pc_le  out  1  PC load enable
if_id_le  out  1  IF/ID register load enable
if_id_flush  out  1  clear IF/ID to NOP
cu_s  out  1  1 = ID mux emits bubble (all control zero)
stall_cnt  out  CNT_W  load-use stall cycles, saturating
flush_cnt  out  CNT_W  branch flushes, saturating

Behaviour:
- Slot state (EX, MEM, WB): {v, rd, rf_en, load}. A slot is "writing" when v & rf_en & rd!=0.
- Forward, per used operand k: compare with EX, then MEM, then WB; the first writing slot with rd==src wins.
  - EX-slot loads never forward from EX.
  - If LOAD_LAT=2, MEM-slot loads do not forward from MEM.
  - src==0 or id_src_used[k]=0 gives 00. fwd_sel is combinational.
- load_use = id_valid & used operand matches a writing EX slot with load=1. If LOAD_LAT=2, a matching writing MEM load also counts.
- Priority, highest first: reset > mem_busy > ex_branch_taken > load_use > normal.
- reset: all slots v=0; counters 0. While reset is high: npc_le=pc_le=if_id_le=0, cu_s=1, if_id_flush=0, fwd_sel=0.
- mem_busy: all LEs 0, cu_s=0, flush=0; slots hold; counters hold.
- Branch: if_id_flush=1, LEs=1, cu_s=1.
  - Next EX slot is a bubble; MEM<=EX, WB<=MEM.
  - flush_cnt+1. A simultaneous load_use is ignored and stall_cnt is unchanged.
- load_use: LEs=0, cu_s=1; EX<=bubble, MEM<=EX, WB<=MEM; stall_cnt+1.
  - Stall repeats each cycle until the condition clears: 1 cycle for LOAD_LAT=1, 2 cycles for LOAD_LAT=2.
- Normal: LEs=1, cu_s=0; EX<={id_valid,id_rd,id_rf_en,id_load}, and the shift advances.
- Counters saturate at all-ones (no wrap).
- Reset mid-stall or mid-flush: state is discarded; the first cycle after reset is normal with empty slots.

Decomposition:
- Package ppu_hazard_pkg holds:
  - fwd-select encodings FWD_RF/FWD_EX/FWD_MEM/FWD_WB.
  - the hazard_slot_t struct {v, rd, rf_en, load}.
  - the BUBBLE_SLOT constant.
- One sub-module: fwd_select. It is purely combinational: one source register plus three slots in, 2-bit select and a load-match flag out. It is instantiated NUM_SRC times via generate.

Test Plan:
1. add r3,r1,r2 then sub r4,r3,r5, back-to-back (LOAD_LAT=1) -> second cycle fwd_sel[1:0]=01; no stall; stall_cnt=0.
2. lw r8 then add r10,r8,r1 -> one cycle with pc_le=0, cu_s=1; next cycle fwd_sel[1:0]=10; stall_cnt=1. With LOAD_LAT=2: two stall cycles, then fwd=11, stall_cnt=2.
3. Writer to r0 followed by a reader of r0 -> fwd_sel=00, no stall.
4. The same rd in EX and WB (r5) and operand r5 -> fwd=01, since EX has priority.
5. ex_branch_taken=1 coinciding with a load_use -> if_id_flush=1, pc_le=1, flush_cnt=1, stall_cnt unchanged. mem_busy held 3 cycles mid-stream -> LEs=0 and slots/counters unchanged. With CNT_W=2, five flushes -> flush_cnt=3.
6. reset asserted during a LOAD_LAT=2 stall -> next cycle counters=0, fwd_sel=0, LEs=0 while reset is high; after release, LEs=1.
